// File: rtl/fir_stream_pipeline.sv
// Streaming FIR filter: registered products, one register per adder-tree level, then a
// round/saturate stage. Latency from accepting cycle to out_valid is log2(TAP_COUNT)+2.
module fir_stream_pipeline #(
  parameter int unsigned DATA_IN_WIDTH  = 16,
  parameter int unsigned TAP_WIDTH      = 16,
  parameter int unsigned TAP_COUNT      = 64,
  parameter int unsigned DATA_OUT_WIDTH = 16,
  parameter int unsigned OUT_SHIFT      = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                             coef_we,
  input  logic [$clog2(TAP_COUNT)-1:0]     coef_addr,
  input  logic signed [TAP_WIDTH-1:0]      coef_data,
  output logic                             out_valid,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out,
  output logic                             sat_flag
);

  localparam int unsigned TAP_AW    = $clog2(TAP_COUNT);
  localparam int unsigned ACC_WIDTH = DATA_IN_WIDTH + TAP_WIDTH + TAP_AW;
  localparam int unsigned NODES     = 2 * TAP_COUNT - 1;

  localparam logic signed [ACC_WIDTH:0] RND_BIAS = ((ACC_WIDTH + 1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH + 2 - DATA_OUT_WIDTH){1'b0}}, {(DATA_OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH + 2 - DATA_OUT_WIDTH){1'b1}}, {(DATA_OUT_WIDTH - 1){1'b0}}};

  logic signed [TAP_WIDTH-1:0]     coef_q  [TAP_COUNT];
  logic signed [DATA_IN_WIDTH-1:0] delay_q [TAP_COUNT-1];
  logic signed [DATA_IN_WIDTH-1:0] tap_in  [TAP_COUNT];
  logic signed [ACC_WIDTH-1:0]     prod    [TAP_COUNT];
  // Heap-ordered tree: node n lives at node_q[n-1]; root is node_q[0], leaf k at TAP_COUNT+k-1.
  logic signed [ACC_WIDTH-1:0]     node_q  [NODES];
  logic [TAP_AW:0]                 valid_q;

  logic signed [ACC_WIDTH:0]        rounded;
  logic signed [ACC_WIDTH:0]        shifted;
  logic signed [DATA_OUT_WIDTH-1:0] out_d;
  logic                             sat_d;

  // Products see the delay line as it will be after this cycle's shift.
  always_comb begin
    tap_in[0] = data_in;
    for (int unsigned k = 1; k < TAP_COUNT; k++) begin
      tap_in[k] = delay_q[k-1];
    end
    for (int unsigned k = 0; k < TAP_COUNT; k++) begin
      prod[k] = ACC_WIDTH'(tap_in[k]) * ACC_WIDTH'(coef_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < TAP_COUNT; k++) begin
        coef_q[k] <= '0;
      end
      for (int unsigned k = 0; k < TAP_COUNT - 1; k++) begin
        delay_q[k] <= '0;
      end
    end else begin
      if (coef_we) begin
        coef_q[coef_addr] <= coef_data;
      end
      if (in_valid) begin
        for (int unsigned k = 0; k < TAP_COUNT - 1; k++) begin
          delay_q[k] <= tap_in[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < NODES; n++) begin
        node_q[n] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int unsigned k = 0; k < TAP_COUNT; k++) begin
        node_q[TAP_COUNT+k-1] <= prod[k];
      end
      for (int unsigned n = 1; n < TAP_COUNT; n++) begin
        node_q[n-1] <= node_q[2*n-1] + node_q[2*n];
      end
      valid_q <= {valid_q[TAP_AW-1:0], in_valid};
    end
  end

  // Extra headroom bit keeps the rounding bias from wrapping the accumulator.
  always_comb begin
    rounded = (ACC_WIDTH + 1)'(node_q[0]) + RND_BIAS;
    shifted = rounded >>> OUT_SHIFT;
    sat_d   = 1'b0;
    out_d   = shifted[DATA_OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      out_d = OUT_MAX[DATA_OUT_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (shifted < OUT_MIN) begin
      out_d = OUT_MIN[DATA_OUT_WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= valid_q[TAP_AW];
      if (valid_q[TAP_AW]) begin
        data_out <= out_d;
        sat_flag <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_pipeline.sv
// Scoreboard bench for fir_stream_pipeline: two instances (OUT_SHIFT 0 and 1) share stimulus;
// a reference model pushes expected outputs, a monitor pops them on out_valid.
module tb_fir_stream_pipeline;

  localparam int N = 8;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic coef_we = 1'b0;
  logic signed [15:0] data_in = '0;
  logic signed [15:0] coef_data = '0;
  logic [2:0] coef_addr = '0;

  logic ov0, ov1, sf0, sf1;
  logic signed [15:0] do0, do1;

  always #5 clk = ~clk;

  fir_stream_pipeline #(
    .DATA_IN_WIDTH(16), .TAP_WIDTH(16), .TAP_COUNT(N), .DATA_OUT_WIDTH(16), .OUT_SHIFT(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(ov0), .data_out(do0),
    .sat_flag(sf0)
  );

  fir_stream_pipeline #(
    .DATA_IN_WIDTH(16), .TAP_WIDTH(16), .TAP_COUNT(N), .DATA_OUT_WIDTH(16), .OUT_SHIFT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(ov1), .data_out(do1),
    .sat_flag(sf1)
  );

  typedef struct {
    int due;
    int val;
    bit sat;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint hist[$];
  longint coef[N];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     last_d[2];
  bit     last_s[2];
  logic   rs_s;

  task automatic cmp(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input longint y, input int s, input int due);
    exp_t   e;
    longint r;
    r = y;
    if (s > 0) r = (y + (longint'(1) <<< (s - 1))) >>> s;
    e.due = due;
    e.sat = 1'b0;
    if (r > 32767) begin
      e.val = 32767;
      e.sat = 1'b1;
    end else if (r < -32768) begin
      e.val = -32768;
      e.sat = 1'b1;
    end else begin
      e.val = int'(r);
    end
    return e;
  endfunction

  task automatic lane_check(input int lane, input logic rs, input logic v,
                            input logic signed [15:0] d, input logic s);
    exp_t e;
    int   qs;
    qs = (lane == 0) ? q0.size() : q1.size();
    if (rs) begin
      cmp($sformatf("L%0d reset out_valid", lane), v, 0);
      cmp($sformatf("L%0d reset data_out", lane), d, 0);
      cmp($sformatf("L%0d reset sat_flag", lane), s, 0);
      last_d[lane] = 0;
      last_s[lane] = 1'b0;
    end else if (v) begin
      if (qs == 0) begin
        cmp($sformatf("L%0d spurious out_valid", lane), v, 0);
      end else begin
        if (lane == 0) e = q0.pop_front();
        else e = q1.pop_front();
        cmp($sformatf("L%0d latency", lane), cyc, e.due);
        cmp($sformatf("L%0d data_out", lane), d, e.val);
        cmp($sformatf("L%0d sat_flag", lane), s, e.sat);
        last_d[lane] = e.val;
        last_s[lane] = e.sat;
      end
    end else begin
      cmp($sformatf("L%0d hold data_out", lane), d, last_d[lane]);
      cmp($sformatf("L%0d hold sat_flag", lane), s, last_s[lane]);
    end
  endtask

  always @(posedge clk) begin
    rs_s = reset;
    cyc++;
    #1;
    lane_check(0, rs_s, ov0, do0, sf0);
    lane_check(1, rs_s, ov1, do1, sf1);
  end

  // Drive one cycle of inputs and update the reference model with what the DUT will sample.
  task automatic step(input bit v, input int d, input bit we, input int a, input int c,
                      input bit rst);
    longint y;
    reset     = rst;
    in_valid  = v;
    data_in   = 16'(d);
    coef_we   = we;
    coef_addr = 3'(a);
    coef_data = 16'(c);
    if (rst) begin
      q0.delete();
      q1.delete();
      hist.delete();
      for (int k = 0; k < N; k++) coef[k] = 0;
    end else begin
      if (v) begin
        hist.push_front(longint'($signed(16'(d))));
        if (hist.size() > N) void'(hist.pop_back());
        y = 0;
        for (int k = 0; k < hist.size(); k++) y += hist[k] * coef[k];
        q0.push_back(mk(y, 0, cyc + LAT));
        q1.push_back(mk(y, 1, cyc + LAT));
      end
      if (we) coef[a] = longint'($signed(16'(c)));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) step(0, 0, 0, 0, 0, 1);

    // Impulse response with coefficients 1..8.
    for (int k = 0; k < N; k++) step(0, 0, 1, k, k + 1, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    idle(8);

    // Same impulse with three idle cycles between samples.
    for (int i = 0; i < N; i++) begin
      step(1, (i == 0) ? 1 : 0, 0, 0, 0, 0);
      idle(3);
    end
    idle(8);

    // Positive and negative saturation.
    for (int k = 0; k < N; k++) step(0, 0, 1, k, 32767, 0);
    for (int i = 0; i < N; i++) step(1, 32767, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(1, -32768, 0, 0, 0, 0);
    idle(8);

    // Rounding (visible on the OUT_SHIFT=1 instance).
    for (int k = 0; k < N; k++) step(0, 0, 1, k, (k == 0) ? 1 : 0, 0);
    step(1, 3, 0, 0, 0, 0);
    step(1, -3, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(8);

    // Coefficient write coinciding with a sample uses the old value.
    step(0, 0, 1, 0, 2, 0);
    step(1, 10, 1, 0, 5, 0);
    step(1, 10, 0, 0, 0, 0);
    idle(8);

    // Mid-stream reset two cycles after a sample, then coefficients read as zero.
    step(1, 7, 0, 0, 0, 0);
    idle(1);
    step(1, 9, 1, 1, 3, 1);
    idle(8);
    for (int i = 0; i < 10; i++) step(1, int'($urandom_range(0, 65535)), 0, 0, 0, 0);
    idle(8);

    // Randomised traffic with interleaved coefficient writes and rare resets.
    for (int k = 0; k < N; k++) step(0, 0, 1, k, int'($urandom_range(0, 511)) - 256, 0);
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 65535)),
           bit'($urandom_range(0, 5) == 0), int'($urandom_range(0, N - 1)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                       : int'($urandom_range(0, 511)) - 256,
           bit'($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
    cmp("L0 drain pending", q0.size(), 0);
    cmp("L1 drain pending", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_stream_pipeline.md
FIR_STREAM_PIPELINE -- requirements
Module: fir_stream_pipeline

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 16: signed input sample width.
REQ-002 SHALL have parameter TAP_WIDTH, default 16: signed coefficient width.
REQ-003 SHALL have parameter TAP_COUNT, default 64: number of taps; power of two, >= 2.
REQ-004 SHALL have parameter DATA_OUT_WIDTH, default 16: signed output width after round/saturate.
REQ-005 SHALL have parameter OUT_SHIFT, default 15: right-shift applied to the accumulator before saturation, 0..ACC_WIDTH-1.
REQ-006 SHALL derive ACC_WIDTH = DATA_IN_WIDTH+TAP_WIDTH+log2(TAP_COUNT), used for products and adder tree.
REQ-007 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-009 SHALL have port in_valid, input, 1: data_in carries a sample this cycle.
REQ-010 SHALL have port data_in, input, DATA_IN_WIDTH: signed sample.
REQ-011 SHALL have port coef_we, input, 1: coefficient write strobe.
REQ-012 SHALL have port coef_addr, input, log2(TAP_COUNT): tap index to write.
REQ-013 SHALL have port coef_data, input, TAP_WIDTH: signed coefficient value.
REQ-014 SHALL have port out_valid, output, 1: data_out and sat_flag valid this cycle.
REQ-015 SHALL have port data_out, output, DATA_OUT_WIDTH: signed filtered sample.
REQ-016 SHALL have port sat_flag, output, 1: data_out was clipped this sample.

Function
REQ-017 SHALL hold TAP_COUNT coefficients in registers, written at coef_addr on any clk edge with coef_we=1; no file initialisation.
REQ-018 SHALL shift the delay line (new sample at index 0) only on cycles with in_valid=1; otherwise hold it unchanged.
REQ-019 SHALL compute y = sum over k of delay[k]*coef[k] using the delay line contents after the accepting shift, all arithmetic signed, full ACC_WIDTH precision, no intermediate truncation.
REQ-020 SHALL register all TAP_COUNT products in stage 1, reduce them through a binary adder tree with one register level per level (log2(TAP_COUNT) stages), then one round/saturate stage.
REQ-021 SHALL assert out_valid exactly L = log2(TAP_COUNT)+2 cycles after the accepting in_valid cycle, one out_valid pulse per accepted sample, order preserved.
REQ-022 SHALL advance the pipeline every cycle (no backpressure); gaps in in_valid propagate as gaps in out_valid.
REQ-023 SHALL round as: add 2^(OUT_SHIFT-1) (nothing when OUT_SHIFT=0), then arithmetic shift right by OUT_SHIFT.
REQ-024 SHALL saturate the rounded value to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1] and set sat_flag=1 with that out_valid when clipping occurred, else 0.
REQ-025 SHALL hold data_out and sat_flag at their last values while out_valid=0.
REQ-026 SHALL, when coef_we and in_valid coincide, form the product for that sample with the old coefficient; new value applies from the next accepted sample.
REQ-027 SHALL ignore coef_addr/coef_data when coef_we=0; repeated writes to one address keep the last.

Reset
REQ-028 SHALL, on a clk edge with reset=1, clear delay line, all pipeline registers, valid pipeline, coefficients, data_out, sat_flag, out_valid to 0.
REQ-029 SHALL give reset priority over in_valid and coef_we in the same cycle (sample and write dropped).
REQ-030 SHALL, when reset asserts mid-stream, drop all in-flight samples: no out_valid from cycle after reset until L cycles after the first post-reset accepted sample.

Verification (bench: TAP_COUNT=8, DATA_IN_WIDTH=16, TAP_WIDTH=16, DATA_OUT_WIDTH=16, OUT_SHIFT=0, L=5)
REQ-031 SHALL check impulse: coefs 1..8 at addr 0..7, then in_valid with data_in 1,0,0,0,0,0,0,0 -> data_out 1,2,3,4,5,6,7,8, first out_valid 5 cycles after the 1 is accepted, sat_flag=0.
REQ-032 SHALL check stalls: same impulse with in_valid low for 3 cycles between each sample -> identical output values, each 5 cycles after its input.
REQ-033 SHALL check saturation: all coefs 32767, eight samples of 32767 -> final data_out 32767, sat_flag=1; eight of -32768 -> -32768, sat_flag=1.
REQ-034 SHALL check rounding: OUT_SHIFT=1, coef[0]=1 others 0; inputs 3, -3, 1 -> data_out 2, -1, 1.
REQ-035 SHALL check coefficient hazard: coef[0]=2, then coef_we writing coef[0]=5 same cycle as input 10, next input 10 (others 0) -> outputs 20, 50.
REQ-036 SHALL check mid-stream reset: 1-cycle reset 2 cycles after accepting a sample -> no out_valid for that sample; all outputs 0 and coefs 0 afterwards until reloaded.
